// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm unit: FSM state encoding, field maxima,
// down-counter width and a wrap-around increment helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_e;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam int         CNT_W    = 12;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_unit_sec_down_counter.sv
// Loadable 12-bit seconds down-counter shared by ring and snooze timing.
// done_o flags the enabled cycle that takes the count from 1 to 0.
module sec_down_counter
  import alarm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] value_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
  assign done_o  = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alarm_unit.sv
// Alarm time register, time-of-day comparator and ring/snooze FSM.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_1hz_i,
  input  logic [4:0] hour_true_i,
  input  logic [5:0] minute_true_i,
  input  logic [5:0] second_true_i,
  input  logic       alarm_en_i,
  input  logic       set_mode_i,
  input  logic       btn_hour_i,
  input  logic       btn_min_i,
  input  logic       ack_i,
  input  logic       snooze_i,
  output logic [4:0] hour_al_o,
  output logic [5:0] minute_al_o,
  output logic [5:0] second_al_o,
  output logic       ringing_o,
  output logic       beep_o
);

  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN * 60);

  state_e           state_q;
  logic [4:0]       hour_al_q;
  logic [5:0]       min_al_q;
  logic             ringing_q, beep_q;
  logic             match;
  logic             cnt_clr, cnt_load, cnt_en, cnt_done;
  logic [CNT_W-1:0] cnt_val, cnt_value;

  assign match = tick_1hz_i && !set_mode_i &&
                 (hour_true_i == hour_al_q) && (minute_true_i == min_al_q) &&
                 (second_true_i == 6'd0);

  // Counter control mirrors the FSM priorities: ack beats snooze beats tick.
  always_comb begin
    cnt_clr  = !alarm_en_i;
    cnt_load = 1'b0;
    cnt_val  = RING_LOAD;
    cnt_en   = 1'b0;
    case (state_q)
      ARMED:   cnt_load = match;
      RINGING: begin
        if (!ack_i) begin
`ifdef ALARM_SNOOZE_EN
          if (snooze_i) begin
            cnt_load = 1'b1;
            cnt_val  = SNOOZE_LOAD;
          end else
`endif
            cnt_en = tick_1hz_i;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!ack_i) begin
          cnt_en   = tick_1hz_i;
          cnt_load = tick_1hz_i && (cnt_value == CNT_W'(1));
        end
      end
`endif
      default: ;
    endcase
  end

  sec_down_counter u_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .value_o    (cnt_value),
    .done_o     (cnt_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      hour_al_q <= '0;
      min_al_q  <= '0;
      ringing_q <= 1'b0;
      beep_q    <= 1'b0;
    end else begin
      if (set_mode_i && btn_hour_i) hour_al_q <= 5'(inc_wrap({1'b0, hour_al_q}, HOUR_MAX));
      if (set_mode_i && btn_min_i)  min_al_q  <= inc_wrap(min_al_q, MIN_MAX);

      if (!alarm_en_i) begin
        state_q   <= IDLE;
        ringing_q <= 1'b0;
        beep_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE:  state_q <= ARMED;
          ARMED: begin
            if (match) begin
              state_q   <= RINGING;
              ringing_q <= 1'b1;
            end
          end
          RINGING: begin
            if (ack_i) begin
              state_q   <= ARMED;
              ringing_q <= 1'b0;
              beep_q    <= 1'b0;
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze_i) begin
              state_q   <= SNOOZE;
              ringing_q <= 1'b0;
              beep_q    <= 1'b0;
            end
`endif
            else if (tick_1hz_i) begin
              if (cnt_done) begin
                state_q   <= ARMED;
                ringing_q <= 1'b0;
                beep_q    <= 1'b0;
              end else begin
                beep_q <= ~beep_q;
              end
            end
          end
`ifdef ALARM_SNOOZE_EN
          SNOOZE: begin
            if (ack_i) begin
              state_q <= ARMED;
            end else if (tick_1hz_i && cnt_done) begin
              state_q   <= RINGING;
              ringing_q <= 1'b1;
            end
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifndef ALARM_SNOOZE_EN
  logic unused_snooze;
  assign unused_snooze = snooze_i;
`endif

  assign hour_al_o   = hour_al_q;
  assign minute_al_o = min_al_q;
  assign second_al_o = 6'd0;
  assign ringing_o   = ringing_q;
  assign beep_o      = beep_q;

endmodule
